// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared constants and types for the UART command-frame decoder.
//   - default header bytes and inter-byte timeout
//   - command opcodes and error codes
//   - frame decoder FSM state encoding
// -----------------------------------------------------------------------------
package uart_pkg;

   localparam int unsigned TIMEOUT_CYC_DEF = 4320;
   localparam logic [7:0]  HDR0_DEF        = 8'h55;
   localparam logic [7:0]  HDR1_DEF        = 8'hAA;

   localparam logic [7:0]  CMD_WR          = 8'h01;
   localparam logic [7:0]  CMD_RD          = 8'h02;

   localparam logic [1:0]  ERR_CHK         = 2'b01;
   localparam logic [1:0]  ERR_CMD         = 2'b10;
   localparam logic [1:0]  ERR_TMO         = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_H1   = 3'd1,
      ST_CMD  = 3'd2,
      ST_ADDR = 3'd3,
      ST_DHI  = 3'd4,
      ST_DLO  = 3'd5,
      ST_CHK  = 3'd6
   } dec_state_t;

endpackage

// File: rtl/uart_frame_decoder.sv
// -----------------------------------------------------------------------------
// uart_frame_decoder
// Parses 7-byte command frames (HDR0 HDR1 CMD ADDR DHI DLO CHK) arriving from
// the UART receiver and issues single-cycle write / read-request strobes to the
// register bank. Flags checksum errors, unknown commands and inter-byte
// timeouts, and resynchronises on the header.
//
// Ports:
//   clk50M     in   system clock
//   rst        in   async active-high reset
//   rx_data    in   received byte, valid with flag_end
//   flag_end   in   one-cycle new-byte strobe
//   wr_en      out  one-cycle write strobe
//   rd_req     out  one-cycle read-request strobe
//   reg_addr   out  register address, held until next good frame
//   reg_wdata  out  {DHI,DLO}, updated by write frames only
//   frame_err  out  one-cycle error strobe
//   err_code   out  01 checksum, 10 bad cmd, 11 timeout; held
//   frame_cnt  out  good-frame counter, wraps
//
// state | meaning
// ------+-------------------------------------------------
// IDLE  | hunting for HDR0
// H1    | HDR0 seen, expecting HDR1 (repeated HDR0 stays)
// CMD   | expecting command byte
// ADDR  | expecting address byte
// DHI   | expecting data high byte
// DLO   | expecting data low byte
// CHK   | expecting checksum; frame evaluated on arrival
// -----------------------------------------------------------------------------
module uart_frame_decoder
   import uart_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
   parameter logic [7:0]  HDR0        = HDR0_DEF,
   parameter logic [7:0]  HDR1        = HDR1_DEF
) (
   input  logic        clk50M,
   input  logic        rst,
   input  logic [7:0]  rx_data,
   input  logic        flag_end,
   output logic        wr_en,
   output logic        rd_req,
   output logic [7:0]  reg_addr,
   output logic [15:0] reg_wdata,
   output logic        frame_err,
   output logic [1:0]  err_code,
   output logic [15:0] frame_cnt
);

   // Down-counter reloaded on every byte; reaching zero outside IDLE is the
   // expiry, which lands exactly TIMEOUT_CYC cycles after the last byte.
   localparam logic [15:0] TMO_LOAD = 16'(TIMEOUT_CYC - 1);

   dec_state_t  state_q;
   dec_state_t  state_nxt;

   logic [15:0] tmo_cnt_q;
   logic        tmo_hit;

   logic [7:0]  cmd_q;
   logic [7:0]  addr_q;
   logic [7:0]  dhi_q;
   logic [7:0]  dlo_q;
   logic [7:0]  sum_q;

   logic        wr_nxt;
   logic        rd_nxt;
   logic        err_nxt;
   logic [1:0]  err_code_nxt;

   // A byte in the expiry cycle takes priority, so the hit is gated by flag_end.
   assign tmo_hit = (state_q != ST_IDLE) && (tmo_cnt_q == '0) && !flag_end;

   // state register
   always_ff @(posedge clk50M or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_nxt;
      end
   end

   // next-state logic
   always_comb begin
      state_nxt = state_q;
      if (flag_end) begin
         case (state_q)
            ST_IDLE: if (rx_data == HDR0) state_nxt = ST_H1;
            ST_H1: begin
               if (rx_data == HDR1)      state_nxt = ST_CMD;
               else if (rx_data == HDR0) state_nxt = ST_H1;
               else                      state_nxt = ST_IDLE;
            end
            ST_CMD:  state_nxt = ST_ADDR;
            ST_ADDR: state_nxt = ST_DHI;
            ST_DHI:  state_nxt = ST_DLO;
            ST_DLO:  state_nxt = ST_CHK;
            ST_CHK:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
         endcase
      end else if (tmo_hit) begin
         state_nxt = ST_IDLE;
      end
   end

   // output decode: next-cycle strobe values
   always_comb begin
      wr_nxt       = 1'b0;
      rd_nxt       = 1'b0;
      err_nxt      = 1'b0;
      err_code_nxt = err_code;
      if (flag_end && (state_q == ST_CHK)) begin
         if (rx_data != sum_q) begin
            err_nxt      = 1'b1;
            err_code_nxt = ERR_CHK;
         end else if (cmd_q == CMD_WR) begin
            wr_nxt = 1'b1;
         end else if (cmd_q == CMD_RD) begin
            rd_nxt = 1'b1;
         end else begin
            err_nxt      = 1'b1;
            err_code_nxt = ERR_CMD;
         end
      end else if (tmo_hit) begin
         err_nxt      = 1'b1;
         err_code_nxt = ERR_TMO;
      end
   end

   // inter-byte timer
   always_ff @(posedge clk50M or posedge rst) begin
      if (rst) begin
         tmo_cnt_q <= '0;
      end else if (flag_end) begin
         tmo_cnt_q <= TMO_LOAD;
      end else if ((state_q != ST_IDLE) && (tmo_cnt_q != '0)) begin
         tmo_cnt_q <= tmo_cnt_q - 16'd1;
      end
   end

   // field capture and running checksum (8-bit, wraps)
   always_ff @(posedge clk50M or posedge rst) begin
      if (rst) begin
         cmd_q  <= '0;
         addr_q <= '0;
         dhi_q  <= '0;
         dlo_q  <= '0;
         sum_q  <= '0;
      end else if (flag_end) begin
         case (state_q)
            ST_CMD: begin
               cmd_q <= rx_data;
               sum_q <= rx_data;
            end
            ST_ADDR: begin
               addr_q <= rx_data;
               sum_q  <= sum_q + rx_data;
            end
            ST_DHI: begin
               dhi_q <= rx_data;
               sum_q <= sum_q + rx_data;
            end
            ST_DLO: begin
               dlo_q <= rx_data;
               sum_q <= sum_q + rx_data;
            end
            default: ;
         endcase
      end
   end

   // registered outputs
   always_ff @(posedge clk50M or posedge rst) begin
      if (rst) begin
         wr_en     <= 1'b0;
         rd_req    <= 1'b0;
         frame_err <= 1'b0;
         err_code  <= 2'b00;
         reg_addr  <= '0;
         reg_wdata <= '0;
         frame_cnt <= '0;
      end else begin
         wr_en     <= wr_nxt;
         rd_req    <= rd_nxt;
         frame_err <= err_nxt;
         err_code  <= err_code_nxt;
         if (wr_nxt || rd_nxt) begin
            reg_addr  <= addr_q;
            frame_cnt <= frame_cnt + 16'd1;
         end
         if (wr_nxt) begin
            reg_wdata <= {dhi_q, dlo_q};
         end
      end
   end

endmodule

// File: tb/tb_uart_frame_decoder.sv
// -----------------------------------------------------------------------------
// tb_uart_frame_decoder
// Directed frames drive the decoder; each expected strobe is queued when its
// frame is sent and a negedge monitor pops and compares whenever the decoder
// presents wr_en, rd_req or frame_err.
// -----------------------------------------------------------------------------
module tb_uart_frame_decoder;

   localparam int unsigned T = 4320;

   localparam int K_WR  = 0;
   localparam int K_RD  = 1;
   localparam int K_ERR = 2;

   typedef struct {
      int          kind;
      logic [7:0]  addr;
      logic [15:0] wdata;
      logic [1:0]  code;
      logic [15:0] cnt;
      int          cyc;   // -1: arrival cycle not checked
   } exp_t;

   logic        clk50M = 1'b0;
   logic        rst    = 1'b1;
   logic [7:0]  rx_data = '0;
   logic        flag_end = 1'b0;
   logic        wr_en;
   logic        rd_req;
   logic [7:0]  reg_addr;
   logic [15:0] reg_wdata;
   logic        frame_err;
   logic [1:0]  err_code;
   logic [15:0] frame_cnt;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;
   int last_cyc    = 0;

   exp_t        sb_q[$];
   logic [7:0]  m_addr  = '0;
   logic [15:0] m_wdata = '0;
   logic [1:0]  m_code  = '0;
   logic [15:0] m_cnt   = '0;

   uart_frame_decoder #(.TIMEOUT_CYC(T), .HDR0(8'h55), .HDR1(8'hAA)) dut (
      .clk50M    (clk50M),
      .rst       (rst),
      .rx_data   (rx_data),
      .flag_end  (flag_end),
      .wr_en     (wr_en),
      .rd_req    (rd_req),
      .reg_addr  (reg_addr),
      .reg_wdata (reg_wdata),
      .frame_err (frame_err),
      .err_code  (err_code),
      .frame_cnt (frame_cnt)
   );

   always #10 clk50M = ~clk50M;

   always @(posedge clk50M) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- model / scoreboard push ----------------
   task automatic push_good(input int kind, input logic [7:0] addr, input logic [15:0] wdata);
      exp_t e;
      m_cnt  = m_cnt + 16'd1;
      m_addr = addr;
      if (kind == K_WR) m_wdata = wdata;
      e.kind = kind; e.addr = m_addr; e.wdata = m_wdata;
      e.code = m_code; e.cnt = m_cnt; e.cyc = -1;
      sb_q.push_back(e);
   endtask

   task automatic push_err(input logic [1:0] code, input int at_cyc);
      exp_t e;
      m_code = code;
      e.kind = K_ERR; e.addr = m_addr; e.wdata = m_wdata;
      e.code = m_code; e.cnt = m_cnt; e.cyc = at_cyc;
      sb_q.push_back(e);
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic send_byte(input logic [7:0] b);
      @(negedge clk50M);
      rx_data  = b;
      flag_end = 1'b1;
      @(posedge clk50M);
      #1;
      flag_end = 1'b0;
      last_cyc = cyc;
   endtask

   task automatic send_bytes(input logic [7:0] bs[$]);
      foreach (bs[i]) send_byte(bs[i]);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk50M);
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk50M) begin
      if (!rst && (wr_en || rd_req || frame_err)) begin
         int k;
         exp_t e;
         k = wr_en ? K_WR : (rd_req ? K_RD : K_ERR);
         chk("strobe_exclusive", 32'($countones({wr_en, rd_req, frame_err})), 32'd1);
         if (sb_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_strobe: got wr=%0b rd=%0b err=%0b expected none (cycle %0d)",
                     wr_en, rd_req, frame_err, cyc);
         end else begin
            e = sb_q.pop_front();
            chk("strobe_kind", 32'(k), 32'(e.kind));
            chk("reg_addr", 32'(reg_addr), 32'(e.addr));
            chk("reg_wdata", 32'(reg_wdata), 32'(e.wdata));
            chk("err_code", 32'(err_code), 32'(e.code));
            chk("frame_cnt", 32'(frame_cnt), 32'(e.cnt));
            if (e.cyc >= 0) chk("timeout_cycle", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   task automatic check_zero(input string tag);
      chk({tag, "_wr_en"},     32'(wr_en),     32'd0);
      chk({tag, "_rd_req"},    32'(rd_req),    32'd0);
      chk({tag, "_frame_err"}, 32'(frame_err), 32'd0);
      chk({tag, "_err_code"},  32'(err_code),  32'd0);
      chk({tag, "_reg_addr"},  32'(reg_addr),  32'd0);
      chk({tag, "_reg_wdata"}, 32'(reg_wdata), 32'd0);
      chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while (sb_q.size() != 0 && n < 50) begin
         @(posedge clk50M);
         n++;
      end
      idle(3);
      if (sb_q.size() != 0) begin
         vectors++;
         miscompares++;
         $display("FAIL %s_missing_strobe: got %0d pending expected 0", tag, sb_q.size());
         sb_q.delete();
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      rst = 1'b1;
      idle(3);
      @(negedge clk50M);
      check_zero("reset");
      rst = 1'b0;
      idle(2);

      // good write
      push_good(K_WR, 8'h10, 16'h1234);
      send_bytes('{8'h55, 8'hAA, 8'h01, 8'h10, 8'h12, 8'h34, 8'h57});
      drain("wr1");

      // read leaves wdata alone, then bad checksum
      push_good(K_RD, 8'h20, 16'h0000);
      send_bytes('{8'h55, 8'hAA, 8'h02, 8'h20, 8'h00, 8'h00, 8'h22});
      push_err(2'b01, -1);
      send_bytes('{8'h55, 8'hAA, 8'h01, 8'h10, 8'h12, 8'h34, 8'h58});
      drain("rd_chk");

      // bad command, then resync through garbage and repeated HDR0
      push_err(2'b10, -1);
      send_bytes('{8'h55, 8'hAA, 8'h07, 8'h10, 8'h12, 8'h34, 8'h5D});
      push_good(K_WR, 8'h10, 16'h1234);
      send_bytes('{8'h00, 8'h55, 8'h55, 8'hAA, 8'h01, 8'h10, 8'h12, 8'h34, 8'h57});
      drain("cmd_resync");

      // checksum wraps past 8 bits: 01+3C+AB+CD = 0x1B5
      push_good(K_WR, 8'h3C, 16'hABCD);
      send_bytes('{8'h55, 8'hAA, 8'h01, 8'h3C, 8'hAB, 8'hCD, 8'hB5});
      drain("sum_wrap");

      // timeout after CMD, then a good frame is accepted
      send_bytes('{8'h55, 8'hAA, 8'h01});
      push_err(2'b11, last_cyc + int'(T));
      idle(int'(T) + 5);
      drain("timeout");
      push_good(K_WR, 8'h10, 16'h1234);
      send_bytes('{8'h55, 8'hAA, 8'h01, 8'h10, 8'h12, 8'h34, 8'h57});
      drain("after_tmo");

      // byte lands exactly on the expiry cycle: frame continues
      send_bytes('{8'h55, 8'hAA, 8'h01});
      idle(int'(T) - 1);
      push_good(K_WR, 8'h10, 16'h1234);
      send_bytes('{8'h10, 8'h12, 8'h34, 8'h57});
      drain("expiry_byte");

      // reset mid-frame: outputs clear, tail bytes produce nothing
      send_bytes('{8'h55, 8'hAA, 8'h01, 8'h10});
      @(negedge clk50M);
      rst = 1'b1;
      #1;
      check_zero("midreset");
      idle(2);
      @(negedge clk50M);
      rst = 1'b0;
      m_cnt = '0; m_addr = '0; m_wdata = '0; m_code = '0;
      send_bytes('{8'h12, 8'h34, 8'h57});
      drain("midreset_tail");
      push_good(K_WR, 8'h10, 16'h1234);
      send_bytes('{8'h55, 8'hAA, 8'h01, 8'h10, 8'h12, 8'h34, 8'h57});
      drain("post_reset");

      // frame counter wrap
      @(negedge clk50M);
      force dut.frame_cnt = 16'hFFFE;
      #2;
      release dut.frame_cnt;
      m_cnt = 16'hFFFE;
      push_good(K_RD, 8'h44, 16'h0000);
      send_bytes('{8'h55, 8'hAA, 8'h02, 8'h44, 8'h00, 8'h00, 8'h46});
      push_good(K_WR, 8'h45, 16'h0102);
      send_bytes('{8'h55, 8'hAA, 8'h01, 8'h45, 8'h01, 8'h02, 8'h49});
      drain("cnt_wrap");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #(20 * 60000);
      $display("FAIL watchdog: got run still active expected finished");
      $fatal(1);
   end

endmodule
